// File: rtl/snake_pkg.sv
// Shared geometry, FSM encoding and pixel indexing for the snake LED matrix.
package snake_pkg;
    localparam int COLS  = 16;
    localparam int ROWS  = 8;
    localparam int X_W   = 4;
    localparam int Y_W   = 3;
    localparam int PIX_W = COLS * ROWS;
    localparam int IDX_W = $clog2(PIX_W);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_DRAW    = 3'd2,
        ST_FOOD    = 3'd3,
        ST_PUBLISH = 3'd4
    } state_t;

    // Row-major bit index; no wrap-around, callers gate with in_range().
    function automatic logic [IDX_W-1:0] pix_idx(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
        pix_idx = IDX_W'(y) * IDX_W'(COLS) + IDX_W'(x);
    endfunction

    function automatic logic in_range(input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y);
        in_range = (int'(x) < COLS) && (int'(y) < ROWS);
    endfunction
endpackage

// File: rtl/frame_writer.sv
// Renders one snake frame into a back buffer and publishes it to the display driver,
// reporting collision, food hit and overflow from the rendered frame.
module frame_writer
    import snake_pkg::*;
#(
    parameter int MAX_SEGS = 128
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             frame_start,
    input  logic             seg_valid,
    output logic             seg_ready,
    input  logic [X_W-1:0]   seg_x,
    input  logic [Y_W-1:0]   seg_y,
    input  logic             seg_last,
    input  logic             food_en,
    input  logic [X_W-1:0]   food_x,
    input  logic [Y_W-1:0]   food_y,
    output logic [PIX_W-1:0] pixelReg,
    output logic             frame_done,
    output logic             busy,
    output logic             collision,
    output logic             food_hit,
    output logic             overflow,
    output state_t           dbg_state
);
    localparam int CNT_W = $clog2(MAX_SEGS + 1);

    // Handshake: a segment beat transfers on a rising edge where seg_valid and
    // seg_ready are both high; seg_ready is high only in DRAW and never depends on seg_valid.
    state_t             r_state;
    logic [PIX_W-1:0]   r_back;
    logic [PIX_W-1:0]   r_pixel;
    logic               r_frame_done, r_busy, r_seg_ready;
    logic               r_coll, r_food_hit, r_ovf;
    logic               r_coll_acc, r_hit_acc, r_ovf_acc, r_head;
    logic [CNT_W-1:0]   r_seg_cnt;
    logic               r_food_en_l;
    logic [X_W-1:0]     r_food_x_l;
    logic [Y_W-1:0]     r_food_y_l;

    logic               w_accept, w_seg_in, w_food_in, w_is_food;
    logic [IDX_W-1:0]   w_seg_idx, w_food_idx;

    assign w_accept   = seg_valid & r_seg_ready;
    assign w_seg_in   = in_range(seg_x, seg_y);
    assign w_seg_idx  = pix_idx(seg_x, seg_y);
    assign w_food_in  = in_range(r_food_x_l, r_food_y_l);
    assign w_food_idx = pix_idx(r_food_x_l, r_food_y_l);
    assign w_is_food  = r_food_en_l && (seg_x == r_food_x_l) && (seg_y == r_food_y_l);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_state      <= ST_IDLE;
            r_back       <= '0;
            r_pixel      <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_seg_ready  <= 1'b0;
            r_coll       <= 1'b0;
            r_food_hit   <= 1'b0;
            r_ovf        <= 1'b0;
            r_coll_acc   <= 1'b0;
            r_hit_acc    <= 1'b0;
            r_ovf_acc    <= 1'b0;
            r_head       <= 1'b0;
            r_seg_cnt    <= '0;
            r_food_en_l  <= 1'b0;
            r_food_x_l   <= '0;
            r_food_y_l   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_back      <= '0;
                    r_food_en_l <= food_en;
                    r_food_x_l  <= food_x;
                    r_food_y_l  <= food_y;
                    r_coll_acc  <= 1'b0;
                    r_hit_acc   <= 1'b0;
                    r_ovf_acc   <= 1'b0;
                    r_seg_cnt   <= '0;
                    r_head      <= 1'b1;
                    r_seg_ready <= 1'b1;
                    r_state     <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (w_accept) begin
                        if (w_seg_in) begin
                            if (r_back[w_seg_idx]) r_coll_acc <= 1'b1;
                            r_back[w_seg_idx] <= 1'b1;
                        end
                        // Only the first beat of a frame is the head.
                        if (r_head) begin
                            r_hit_acc <= w_is_food;
                            r_head    <= 1'b0;
                        end
                        r_seg_cnt <= r_seg_cnt + CNT_W'(1);
                        if (seg_last) begin
                            r_seg_ready <= 1'b0;
                            r_state     <= ST_FOOD;
                        end else if (r_seg_cnt == CNT_W'(MAX_SEGS - 1)) begin
                            r_ovf_acc   <= 1'b1;
                            r_seg_ready <= 1'b0;
                            r_state     <= ST_FOOD;
                        end
                    end
                end
                ST_FOOD: begin
                    if (r_food_en_l && w_food_in) r_back[w_food_idx] <= 1'b1;
                    r_state <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    r_pixel      <= r_back;
                    r_coll       <= r_coll_acc;
                    r_food_hit   <= r_hit_acc;
                    r_ovf        <= r_ovf_acc;
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_seg_ready <= 1'b0;
                end
            endcase
        end
    end

    assign seg_ready  = r_seg_ready;
    assign pixelReg   = r_pixel;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign collision  = r_coll;
    assign food_hit   = r_food_hit;
    assign overflow   = r_ovf;
    assign dbg_state  = r_state;
endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: drivers push expected frames, a monitor checks each publish.
module tb_frame_writer;
    import snake_pkg::*;

    localparam int MAXS = 4;
    localparam int EW   = PIX_W + 3;

    logic             clk = 1'b0;
    logic             aclr = 1'b1;
    logic             frame_start = 1'b0;
    logic             seg_valid = 1'b0;
    logic             seg_last = 1'b0;
    logic             food_en = 1'b0;
    logic [X_W-1:0]   seg_x = '0;
    logic [Y_W-1:0]   seg_y = '0;
    logic [X_W-1:0]   food_x = '0;
    logic [Y_W-1:0]   food_y = '0;
    logic             seg_ready, frame_done, busy, collision, food_hit, overflow;
    logic [PIX_W-1:0] pixelReg;
    state_t           dbg_state;

    frame_writer #(.MAX_SEGS(MAXS)) dut (
        .clk(clk), .aclr(aclr), .frame_start(frame_start),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_x(seg_x), .seg_y(seg_y),
        .seg_last(seg_last), .food_en(food_en), .food_x(food_x), .food_y(food_y),
        .pixelReg(pixelReg), .frame_done(frame_done), .busy(busy),
        .collision(collision), .food_hit(food_hit), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    // ---- clock / cycle counter ----
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- scoreboard state ----
    int               n_vec = 0;
    int               n_miss = 0;
    logic [EW-1:0]    exp_q[$];
    int               exp_t_q[$];
    logic [PIX_W-1:0] last_pix = '0;
    int               acc_edge = 0;

    function automatic logic [PIX_W-1:0] bit_at(input int i);
        logic [PIX_W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [PIX_W-1:0] act,
                         input logic [PIX_W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // ---- monitor: compare every published frame against the queue ----
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            t;
        if (frame_done) begin
            check("done_pulse_width", PIX_W'(prev_done), '0);
            if (exp_q.size() == 0 || exp_t_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_frame_done: got pulse at cycle %0d, want none", cyc);
            end else begin
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("pixelReg", pixelReg, e[EW-1:3]);
                check("collision", PIX_W'(collision), PIX_W'(e[2]));
                check("food_hit", PIX_W'(food_hit), PIX_W'(e[1]));
                check("overflow", PIX_W'(overflow), PIX_W'(e[0]));
                check("done_latency", PIX_W'(cyc), PIX_W'(t));
            end
        end
        prev_done <= frame_done;
    end

    // ---- driver tasks (all entered and left at a falling edge) ----
    task automatic start_frame(input bit fe, input logic [X_W-1:0] fx,
                               input logic [Y_W-1:0] fy);
        food_en = fe;
        food_x  = fx;
        food_y  = fy;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic send_beat(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                             input bit last, input bit ends);
        bit ok;
        ok = 1'b0;
        seg_valid = 1'b1;
        seg_x = x;
        seg_y = y;
        seg_last = last;
        for (int k = 0; k < 50; k++) begin
            if (seg_ready) begin
                acc_edge = cyc + 1;
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        seg_valid = 1'b0;
        seg_last = 1'b0;
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL beat_timeout: got no seg_ready in 50 cycles, want acceptance");
        end else if (ends) begin
            exp_t_q.push_back(acc_edge + 2);
        end
    endtask

    task automatic wait_idle(input logic [PIX_W-1:0] pix);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL frame_timeout: got busy=%0b pending=%0d, want idle", busy, exp_q.size());
        end
        last_pix = pix;
        @(negedge clk);
    endtask

    // ---- stimulus ----
    logic [PIX_W-1:0] p;

    initial begin
        aclr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pixelReg", pixelReg, '0);
        check("rst_busy", PIX_W'(busy), '0);
        check("rst_seg_ready", PIX_W'(seg_ready), '0);
        check("rst_frame_done", PIX_W'(frame_done), '0);
        check("rst_flags", PIX_W'({collision, food_hit, overflow}), '0);
        check("rst_state", PIX_W'(dbg_state), PIX_W'(ST_IDLE));
        aclr = 1'b1;
        @(negedge clk);

        // corners, no food
        p = bit_at(0) | bit_at(127);
        exp_q.push_back({p, 3'b000});
        start_frame(1'b0, 4'd0, 3'd0);
        send_beat(4'd0, 3'd0, 1'b0, 1'b0);
        send_beat(4'd15, 3'd7, 1'b1, 1'b1);
        wait_idle(p);

        // seg_valid held while IDLE is not accepted, published frame holds
        seg_valid = 1'b1;
        seg_x = 4'd9;
        seg_y = 3'd5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_seg_ready", PIX_W'(seg_ready), '0);
            check("idle_busy", PIX_W'(busy), '0);
            check("idle_pixelReg", pixelReg, last_pix);
        end
        seg_valid = 1'b0;

        // self-collision, with a stray frame_start pulse during DRAW
        p = bit_at(35) | bit_at(36);
        exp_q.push_back({p, 3'b100});
        start_frame(1'b0, 4'd0, 3'd0);
        send_beat(4'd3, 3'd2, 1'b0, 1'b0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("draw_pixelReg_held", pixelReg, last_pix);
        send_beat(4'd4, 3'd2, 1'b0, 1'b0);
        check("draw_pixelReg_held2", pixelReg, last_pix);
        send_beat(4'd3, 3'd2, 1'b1, 1'b1);
        wait_idle(p);
        repeat (4) @(negedge clk);
        check("no_restart_busy", PIX_W'(busy), '0);

        // head lands on food; food cell overlapping a segment is not a collision
        p = bit_at(21) | bit_at(22);
        exp_q.push_back({p, 3'b010});
        start_frame(1'b1, 4'd5, 3'd1);
        send_beat(4'd5, 3'd1, 1'b0, 1'b0);
        send_beat(4'd6, 3'd1, 1'b1, 1'b1);
        wait_idle(p);

        // food drawn elsewhere, no hit
        p = bit_at(17) | bit_at(58);
        exp_q.push_back({p, 3'b000});
        start_frame(1'b1, 4'd10, 3'd3);
        send_beat(4'd1, 3'd1, 1'b1, 1'b1);
        wait_idle(p);

        // overflow: MAXS beats without seg_last, the next one is refused
        p = bit_at(0) | bit_at(1) | bit_at(2) | bit_at(3);
        exp_q.push_back({p, 3'b001});
        start_frame(1'b0, 4'd0, 3'd0);
        send_beat(4'd0, 3'd0, 1'b0, 1'b0);
        send_beat(4'd1, 3'd0, 1'b0, 1'b0);
        send_beat(4'd2, 3'd0, 1'b0, 1'b0);
        send_beat(4'd3, 3'd0, 1'b0, 1'b1);
        seg_valid = 1'b1;
        seg_x = 4'd4;
        seg_y = 3'd0;
        for (int k = 0; k < 4; k++) begin
            check("ovf_seg_ready", PIX_W'(seg_ready), '0);
            @(negedge clk);
        end
        seg_valid = 1'b0;
        wait_idle(p);

        // reset mid-DRAW after 3 beats discards the frame
        start_frame(1'b0, 4'd0, 3'd0);
        send_beat(4'd8, 3'd2, 1'b0, 1'b0);
        send_beat(4'd9, 3'd2, 1'b0, 1'b0);
        send_beat(4'd10, 3'd2, 1'b0, 1'b0);
        check("pre_reset_state", PIX_W'(dbg_state), PIX_W'(ST_DRAW));
        #2 aclr = 1'b0;
        #1;
        check("mid_rst_pixelReg", pixelReg, '0);
        check("mid_rst_busy", PIX_W'(busy), '0);
        check("mid_rst_seg_ready", PIX_W'(seg_ready), '0);
        check("mid_rst_flags", PIX_W'({collision, food_hit, overflow}), '0);
        @(negedge clk);
        aclr = 1'b1;
        @(negedge clk);

        // recovery frame after reset
        p = bit_at(71) | bit_at(112);
        exp_q.push_back({p, 3'b000});
        start_frame(1'b1, 4'd0, 3'd7);
        send_beat(4'd7, 3'd4, 1'b1, 1'b1);
        wait_idle(p);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want finish");
        $fatal(1, "watchdog");
    end
endmodule
